// File: rtl/tlp_pkg.sv
// Shared constants for the TLP stream detector: K symbols, error codes,
// FSM encoding and one-hot positions of the decoded TLP type.
package tlp_pkg;

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_SHORT = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_FRAME = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam int TT_W      = 10;
   localparam int TT_MRD    = 0;
   localparam int TT_MWR    = 1;
   localparam int TT_IORD   = 2;
   localparam int TT_IOWR   = 3;
   localparam int TT_CFGRD0 = 4;
   localparam int TT_CFGWR0 = 5;
   localparam int TT_CFGRD1 = 6;
   localparam int TT_CFGWR1 = 7;
   localparam int TT_CPL    = 8;
   localparam int TT_CPLD   = 9;

   localparam logic [2:0] FMT_3DW_ND = 3'b000;
   localparam logic [2:0] FMT_4DW_ND = 3'b001;
   localparam logic [2:0] FMT_3DW_D  = 3'b010;
   localparam logic [2:0] FMT_4DW_D  = 3'b011;

   localparam logic [4:0] TYP_MEM  = 5'b00000;
   localparam logic [4:0] TYP_IO   = 5'b00010;
   localparam logic [4:0] TYP_CFG0 = 5'b00100;
   localparam logic [4:0] TYP_CFG1 = 5'b00101;
   localparam logic [4:0] TYP_CPL  = 5'b01010;

   typedef struct packed {
      logic [2:0] fmt;
      logic [4:0] typ;
   } tlp_hdr0_t;

endpackage

// File: rtl/tlp_type_decoder.sv
// Combinational decode of the fmt/type header byte into a one-hot TLP type.
// Unrecognised fmt/type combinations decode to all-zero.
module tlp_type_decoder
   import tlp_pkg::*;
(
   input  logic [7:0]      type_byte_i,
   output logic [TT_W-1:0] type_onehot_o
);

   tlp_hdr0_t hdr;
   assign hdr = tlp_hdr0_t'(type_byte_i);

   always_comb begin
      type_onehot_o = '0;
      case (hdr.typ)
         TYP_MEM: begin
            if (hdr.fmt == FMT_3DW_ND || hdr.fmt == FMT_4DW_ND) type_onehot_o[TT_MRD] = 1'b1;
            else if (hdr.fmt == FMT_3DW_D || hdr.fmt == FMT_4DW_D) type_onehot_o[TT_MWR] = 1'b1;
         end
         TYP_IO: begin
            if (hdr.fmt == FMT_3DW_ND) type_onehot_o[TT_IORD] = 1'b1;
            else if (hdr.fmt == FMT_3DW_D) type_onehot_o[TT_IOWR] = 1'b1;
         end
         TYP_CFG0: begin
            if (hdr.fmt == FMT_3DW_ND) type_onehot_o[TT_CFGRD0] = 1'b1;
            else if (hdr.fmt == FMT_3DW_D) type_onehot_o[TT_CFGWR0] = 1'b1;
         end
         TYP_CFG1: begin
            if (hdr.fmt == FMT_3DW_ND) type_onehot_o[TT_CFGRD1] = 1'b1;
            else if (hdr.fmt == FMT_3DW_D) type_onehot_o[TT_CFGWR1] = 1'b1;
         end
         TYP_CPL: begin
            if (hdr.fmt == FMT_3DW_ND) type_onehot_o[TT_CPL] = 1'b1;
            else if (hdr.fmt == FMT_3DW_D) type_onehot_o[TT_CPLD] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/tlp_stream_detector.sv
// Frames TLPs out of a symbol stream (STP ... END/EDB), captures data bytes,
// reports good/nullified/errored TLPs and keeps saturating event counters.
//
// state | meaning
// IDLE  | waiting for STP, everything else ignored
// RECV  | capturing data bytes of a TLP
// DROP  | overflowed TLP, discard until the next K symbol
module tlp_stream_detector
   import tlp_pkg::*;
#(
   parameter int  MIN_LEN  = 8,
   parameter int  MAX_LEN  = 32,
   parameter int  TYPE_IDX = 2,
   parameter int  CNT_W    = 8,
   localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           data_in,
   input  logic                 datak,
   input  logic                 cnt_clr,
   output logic                 tlp_valid,
   output logic [MAX_LEN*8-1:0] tlp_data,
   output logic [LEN_W-1:0]     tlp_len,
   output logic [TT_W-1:0]      tlp_type,
   output logic                 nullified,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [CNT_W-1:0]     good_cnt,
   output logic [CNT_W-1:0]     null_cnt,
   output logic [CNT_W-1:0]     bad_cnt
);

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

   logic [1:0]           state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [MAX_LEN*8-1:0] cap_q, cap_d;
   logic                 good_d, null_d, err_d;
   logic [1:0]           code_d;
   logic [MAX_LEN*8-1:0] cap_masked;
   logic [TT_W-1:0]      type_dec;
   logic                 is_stp, is_end, is_edb;

   logic                 tlp_valid_q, nullified_q, err_q;
   logic [1:0]           err_code_q;
   logic [MAX_LEN*8-1:0] tlp_data_q;
   logic [LEN_W-1:0]     tlp_len_q;
   logic [TT_W-1:0]      tlp_type_q;
   logic [CNT_W-1:0]     good_cnt_q, null_cnt_q, bad_cnt_q;

   assign is_stp = datak && (data_in == K_STP);
   assign is_end = datak && (data_in == K_END);
   assign is_edb = datak && (data_in == K_EDB);

   // Bytes beyond len may hold stale data from an earlier TLP; zero them on delivery.
   always_comb begin
      cap_masked = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (LEN_W'(i) < len_q) cap_masked[i*8 +: 8] = cap_q[i*8 +: 8];
      end
   end

   tlp_type_decoder u_type_dec (
      .type_byte_i   (cap_masked[TYPE_IDX*8 +: 8]),
      .type_onehot_o (type_dec)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cap_d   = cap_q;
      good_d  = 1'b0;
      null_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      case (state_q)
         ST_IDLE: begin
            if (is_stp) begin
               state_d = ST_RECV;
               len_d   = '0;
            end
         end
         ST_RECV: begin
            if (!datak) begin
               if (len_q == MAX_L) begin
                  err_d   = 1'b1;
                  code_d  = ERR_OVF;
                  state_d = ST_DROP;
               end else begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     if (len_q == LEN_W'(i)) cap_d[i*8 +: 8] = data_in;
                  end
                  len_d = len_q + LEN_W'(1);
               end
            end else if (is_end) begin
               if (len_q >= MIN_L) begin
                  good_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_SHORT;
               end
               state_d = ST_IDLE;
            end else if (is_edb) begin
               null_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (is_stp) begin
               err_d  = 1'b1;
               code_d = ERR_FRAME;
               len_d  = '0;
            end else begin
               err_d   = 1'b1;
               code_d  = ERR_FRAME;
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (datak) begin
               state_d = is_stp ? ST_RECV : ST_IDLE;
               len_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cap_q       <= '0;
         tlp_valid_q <= 1'b0;
         nullified_q <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         tlp_data_q  <= '0;
         tlp_len_q   <= '0;
         tlp_type_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cap_q       <= cap_d;
         tlp_valid_q <= good_d;
         nullified_q <= null_d;
         err_q       <= err_d;
         err_code_q  <= code_d;
         if (good_d) begin
            tlp_data_q <= cap_masked;
            tlp_len_q  <= len_q;
            tlp_type_q <= type_dec;
         end
      end
   end

   // Counters advance on the same edge that raises the matching pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         good_cnt_q <= '0;
         null_cnt_q <= '0;
         bad_cnt_q  <= '0;
      end else if (cnt_clr) begin
         good_cnt_q <= '0;
         null_cnt_q <= '0;
         bad_cnt_q  <= '0;
      end else begin
         if (good_d && (good_cnt_q != '1)) good_cnt_q <= good_cnt_q + CNT_W'(1);
         if (null_d && (null_cnt_q != '1)) null_cnt_q <= null_cnt_q + CNT_W'(1);
         if (err_d && (bad_cnt_q != '1))   bad_cnt_q  <= bad_cnt_q + CNT_W'(1);
      end
   end

   assign tlp_valid = tlp_valid_q;
   assign nullified = nullified_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign tlp_data  = tlp_data_q;
   assign tlp_len   = tlp_len_q;
   assign tlp_type  = tlp_type_q;
   assign good_cnt  = good_cnt_q;
   assign null_cnt  = null_cnt_q;
   assign bad_cnt   = bad_cnt_q;

endmodule
